instruction_loader: RTL and testbench

- Consumer end of the machine-code path: accepts the program image as a host byte stream, packs bytes into instruction words and writes them into the CPU instruction memory.
- Sits between the host/bench byte source and the `cpu` instruction memory write port.
- Holds the CPU in halt until a complete, well-formed image is loaded, then releases it via `cpu_run_out`.

---
 rtl/instruction_loader_if.sv | 33 +++
 rtl/instruction_loader.sv | 118 +++++++++++
 tb/tb_instruction_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory write signals of the instruction loader.
// The host side is the master; the loader is the slave.
interface instruction_loader_if #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDRESS_WIDTH     = 8
);
    logic                         load_start_in;
    logic [7:0]                   byte_in;
    logic                         byte_valid_in;
    logic                         byte_ready_out;
    logic                         load_done_in;
    logic                         mem_write_enable_out;
    logic [ADDRESS_WIDTH-1:0]     mem_write_address_out;
    logic [INSTRUCTION_WIDTH-1:0] mem_write_data_out;
    logic [ADDRESS_WIDTH:0]       word_count_out;
    logic                         cpu_run_out;
    logic                         overflow_error_out;
    logic                         partial_error_out;

    modport master (
        output load_start_in, byte_in, byte_valid_in, load_done_in,
        input  byte_ready_out, mem_write_enable_out, mem_write_address_out,
               mem_write_data_out, word_count_out, cpu_run_out,
               overflow_error_out, partial_error_out
    );

    modport slave (
        input  load_start_in, byte_in, byte_valid_in, load_done_in,
        output byte_ready_out, mem_write_enable_out, mem_write_address_out,
               mem_write_data_out, word_count_out, cpu_run_out,
               overflow_error_out, partial_error_out
    );
endinterface

// File: rtl/instruction_loader.sv
// Packs a little-endian host byte stream into instruction words, writes them to
// instruction memory, and holds the CPU halted until a clean image is loaded.
module instruction_loader #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDRESS_WIDTH     = 8
) (
    input logic            clock_in,
    input logic            reset_in,
    instruction_loader_if.slave bus
);
    localparam int BYTES = INSTRUCTION_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDRESS_WIDTH:0] CAPACITY = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;

    state_t                       state, state_n;
    logic [BCW-1:0]               byte_count, byte_count_n;
    logic [ADDRESS_WIDTH:0]       word_count, word_count_n;
    logic [INSTRUCTION_WIDTH-1:0] word, word_n;
    logic                         done_pending, done_pending_n;
    logic                         overflow, overflow_n;
    logic                         partial, partial_n;
    logic                         accept;

    // Ready is decoded from the state register only, so valid never loops back into ready.
    assign accept = (state == LOAD) && bus.byte_valid_in;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state        <= IDLE;
            byte_count   <= '0;
            word_count   <= '0;
            word         <= '0;
            done_pending <= 1'b0;
            overflow     <= 1'b0;
            partial      <= 1'b0;
        end else begin
            state        <= state_n;
            byte_count   <= byte_count_n;
            word_count   <= word_count_n;
            word         <= word_n;
            done_pending <= done_pending_n;
            overflow     <= overflow_n;
            partial      <= partial_n;
        end
    end

    always_comb begin
        state_n        = state;
        byte_count_n   = byte_count;
        word_count_n   = word_count;
        word_n         = word;
        done_pending_n = done_pending;
        overflow_n     = overflow;
        partial_n      = partial;

        if (bus.load_start_in) begin
            // A restart during WRITE still emits this cycle's strobe; only the counters reset.
            state_n        = LOAD;
            byte_count_n   = '0;
            word_count_n   = '0;
            word_n         = '0;
            done_pending_n = 1'b0;
            overflow_n     = 1'b0;
            partial_n      = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (word_count == CAPACITY) begin
                            state_n    = ERROR;
                            overflow_n = 1'b1;
                        end else begin
                            for (int i = 0; i < BYTES; i++) begin
                                if (byte_count == BCW'(i)) word_n[i*8 +: 8] = bus.byte_in;
                            end
                            if (byte_count == LAST_BYTE) begin
                                state_n        = WRITE;
                                byte_count_n   = '0;
                                done_pending_n = bus.load_done_in;
                            end else begin
                                byte_count_n = byte_count + BCW'(1);
                                if (bus.load_done_in) begin
                                    state_n   = ERROR;
                                    partial_n = 1'b1;
                                end
                            end
                        end
                    end else if (bus.load_done_in) begin
                        if (byte_count == '0) begin
                            state_n = DONE;
                        end else begin
                            state_n   = ERROR;
                            partial_n = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_count_n   = word_count + (ADDRESS_WIDTH+1)'(1);
                    state_n        = done_pending ? DONE : LOAD;
                    done_pending_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready_out        = (state == LOAD);
    assign bus.mem_write_enable_out  = (state == WRITE);
    assign bus.mem_write_address_out = (state == WRITE) ? word_count[ADDRESS_WIDTH-1:0] : '0;
    assign bus.mem_write_data_out    = (state == WRITE) ? word : '0;
    assign bus.word_count_out        = word_count;
    assign bus.cpu_run_out           = (state == DONE);
    assign bus.overflow_error_out    = overflow;
    assign bus.partial_error_out     = partial;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: one full-size instance and one with a
// four-word memory for the capacity case, driven from shared stimulus.
module tb_instruction_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic       done = 1'b0;
    logic [7:0] b = 8'h00;
    bit         sel2 = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         rdy_viol = 0;
    logic [39:0] q8[$];
    logic [39:0] q2[$];

    always #5 clk = ~clk;

    instruction_loader_if #(.INSTRUCTION_WIDTH(32), .ADDRESS_WIDTH(8)) bus8();
    instruction_loader_if #(.INSTRUCTION_WIDTH(32), .ADDRESS_WIDTH(2)) bus2();

    assign bus8.load_start_in = start;
    assign bus8.byte_in       = b;
    assign bus8.byte_valid_in = valid;
    assign bus8.load_done_in  = done;
    assign bus2.load_start_in = start;
    assign bus2.byte_in       = b;
    assign bus2.byte_valid_in = valid;
    assign bus2.load_done_in  = done;

    instruction_loader #(.INSTRUCTION_WIDTH(32), .ADDRESS_WIDTH(8)) dut8 (
        .clock_in(clk), .reset_in(rst), .bus(bus8));
    instruction_loader #(.INSTRUCTION_WIDTH(32), .ADDRESS_WIDTH(2)) dut2 (
        .clock_in(clk), .reset_in(rst), .bus(bus2));

    wire rdy = sel2 ? bus2.byte_ready_out : bus8.byte_ready_out;

    always @(negedge clk) begin
        if (bus8.mem_write_enable_out) begin
            q8.push_back({bus8.mem_write_address_out, bus8.mem_write_data_out});
            if (bus8.byte_ready_out) rdy_viol++;
        end
        if (bus2.mem_write_enable_out) begin
            q2.push_back({6'd0, bus2.mem_write_address_out, bus2.mem_write_data_out});
            if (bus2.byte_ready_out) rdy_viol++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one beat and holds it until the selected loader is ready.
    task automatic xfer(input logic v, input logic [7:0] d, input logic dn);
        bit got = 1'b0;
        b = d; valid = v; done = dn;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rdy) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL xfer_timeout byte=%h ready never seen", d);
        end
        @(posedge clk); #1;
        valid = 1'b0; done = 1'b0;
    endtask

    function automatic logic [7:0] t6_byte(input int i);
        return 8'(8'h30 + i * 7);
    endfunction

    task automatic test_reset();
        logic [31:0] obs [8];
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        obs = '{32'(bus8.byte_ready_out), 32'(bus8.mem_write_enable_out),
                32'(bus8.mem_write_address_out), bus8.mem_write_data_out,
                32'(bus8.word_count_out), 32'(bus8.cpu_run_out),
                32'(bus8.overflow_error_out), 32'(bus8.partial_error_out)};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset_out%0d got=%h want=0", i, obs[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_load();
        logic [7:0] img [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
        q8.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) xfer(1'b1, img[i], 1'b0);
        xfer(1'b0, 8'h00, 1'b1);
        checks++; if (q8.size() !== 2) begin failures++; $display("FAIL basic_writes got=%0d want=2", q8.size()); end
        if (q8.size() == 2) begin
            checks++; if (q8[0] !== {8'd0, 32'h00000013}) begin failures++; $display("FAIL basic_w0 got=%h want=%h", q8[0], {8'd0, 32'h00000013}); end
            checks++; if (q8[1] !== {8'd1, 32'h00108093}) begin failures++; $display("FAIL basic_w1 got=%h want=%h", q8[1], {8'd1, 32'h00108093}); end
        end
        checks++; if (bus8.word_count_out !== 9'd2) begin failures++; $display("FAIL basic_count got=%0d want=2", bus8.word_count_out); end
        checks++; if (bus8.cpu_run_out !== 1'b1) begin failures++; $display("FAIL basic_run got=%b want=1", bus8.cpu_run_out); end
        checks++; if ({bus8.overflow_error_out, bus8.partial_error_out} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b want=00", {bus8.overflow_error_out, bus8.partial_error_out}); end
        repeat (3) @(posedge clk); #1;
        checks++; if ({bus8.cpu_run_out, bus8.byte_ready_out} !== 2'b10) begin failures++; $display("FAIL done_hold got=%b want=10", {bus8.cpu_run_out, bus8.byte_ready_out}); end
    endtask

    task automatic test_partial();
        q8.delete();
        pulse_start();
        checks++; if ({bus8.cpu_run_out, bus8.byte_ready_out} !== 2'b01) begin failures++; $display("FAIL restart_from_done got=%b want=01", {bus8.cpu_run_out, bus8.byte_ready_out}); end
        checks++; if (bus8.word_count_out !== 9'd0) begin failures++; $display("FAIL restart_count got=%0d want=0", bus8.word_count_out); end
        xfer(1'b1, 8'hAA, 1'b0);
        xfer(1'b1, 8'hBB, 1'b0);
        xfer(1'b1, 8'hCC, 1'b0);
        xfer(1'b0, 8'h00, 1'b1);
        repeat (3) @(posedge clk); #1;
        checks++; if (q8.size() !== 0) begin failures++; $display("FAIL partial_nowrite got=%0d want=0", q8.size()); end
        checks++; if (bus8.partial_error_out !== 1'b1) begin failures++; $display("FAIL partial_flag got=%b want=1", bus8.partial_error_out); end
        checks++; if ({bus8.cpu_run_out, bus8.byte_ready_out, bus8.overflow_error_out} !== 3'b000) begin failures++; $display("FAIL partial_state got=%b want=000", {bus8.cpu_run_out, bus8.byte_ready_out, bus8.overflow_error_out}); end
    endtask

    task automatic test_overflow();
        sel2 = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q2.delete();
        pulse_start();
        for (int i = 0; i < 16; i++) xfer(1'b1, 8'(i), 1'b0);
        xfer(1'b1, 8'hFF, 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++; if (q2.size() !== 4) begin failures++; $display("FAIL ovf_writes got=%0d want=4", q2.size()); end
        for (int k = 0; k < 4 && k < q2.size(); k++) begin
            logic [39:0] exp;
            exp = {8'(k), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            checks++; if (q2[k] !== exp) begin failures++; $display("FAIL ovf_w%0d got=%h want=%h", k, q2[k], exp); end
        end
        checks++; if (bus2.overflow_error_out !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", bus2.overflow_error_out); end
        checks++; if (bus2.word_count_out !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d want=4", bus2.word_count_out); end
        checks++; if ({bus2.cpu_run_out, bus2.partial_error_out} !== 2'b00) begin failures++; $display("FAIL ovf_state got=%b want=00", {bus2.cpu_run_out, bus2.partial_error_out}); end
        sel2 = 1'b0;
    endtask

    task automatic test_done_with_last_byte();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q8.delete();
        pulse_start();
        xfer(1'b1, 8'h11, 1'b0);
        xfer(1'b1, 8'h22, 1'b0);
        xfer(1'b1, 8'h33, 1'b0);
        xfer(1'b1, 8'h44, 1'b1);
        checks++; if (bus8.mem_write_enable_out !== 1'b1) begin failures++; $display("FAIL sim_latency got=%b want=1", bus8.mem_write_enable_out); end
        repeat (2) @(posedge clk); #1;
        checks++; if (q8.size() !== 1) begin failures++; $display("FAIL sim_writes got=%0d want=1", q8.size()); end
        if (q8.size() == 1) begin
            checks++; if (q8[0] !== {8'd0, 32'h44332211}) begin failures++; $display("FAIL sim_word got=%h want=%h", q8[0], {8'd0, 32'h44332211}); end
        end
        checks++; if ({bus8.cpu_run_out, bus8.partial_error_out, bus8.overflow_error_out} !== 3'b100) begin failures++; $display("FAIL sim_state got=%b want=100", {bus8.cpu_run_out, bus8.partial_error_out, bus8.overflow_error_out}); end
    endtask

    task automatic test_midload_reset();
        pulse_start();
        xfer(1'b1, 8'h01, 1'b0);
        xfer(1'b1, 8'h02, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus8.byte_ready_out, bus8.mem_write_enable_out, bus8.cpu_run_out,
             bus8.overflow_error_out, bus8.partial_error_out} !== 5'b0 ||
            bus8.word_count_out !== 9'd0 || bus8.mem_write_data_out !== 32'd0) begin
            failures++;
            $display("FAIL midreset_outs ready=%b we=%b run=%b cnt=%0d want all 0",
                     bus8.byte_ready_out, bus8.mem_write_enable_out, bus8.cpu_run_out, bus8.word_count_out);
        end
        rst = 1'b0;
        q8.delete();
        pulse_start();
        xfer(1'b1, 8'hDE, 1'b0);
        xfer(1'b1, 8'hAD, 1'b0);
        xfer(1'b1, 8'hBE, 1'b0);
        xfer(1'b1, 8'hEF, 1'b0);
        repeat (2) @(posedge clk); #1;
        checks++; if (q8.size() !== 1 || q8[0] !== {8'd0, 32'hEFBEADDE}) begin failures++; $display("FAIL midreset_word n=%0d got=%h want=%h", q8.size(), (q8.size() > 0) ? q8[0] : 40'd0, {8'd0, 32'hEFBEADDE}); end
        checks++; if (bus8.word_count_out !== 9'd1) begin failures++; $display("FAIL midreset_count got=%0d want=1", bus8.word_count_out); end
    endtask

    task automatic test_back_to_back();
        q8.delete();
        rdy_viol = 0;
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            xfer(1'b1, t6_byte(i), 1'b0);
        end
        xfer(1'b0, 8'h00, 1'b1);
        checks++; if (q8.size() !== 8) begin failures++; $display("FAIL b2b_writes got=%0d want=8", q8.size()); end
        for (int k = 0; k < 8 && k < q8.size(); k++) begin
            logic [39:0] exp;
            exp = {8'(k), t6_byte(4*k+3), t6_byte(4*k+2), t6_byte(4*k+1), t6_byte(4*k)};
            checks++; if (q8[k] !== exp) begin failures++; $display("FAIL b2b_w%0d got=%h want=%h", k, q8[k], exp); end
        end
        checks++; if (rdy_viol !== 0) begin failures++; $display("FAIL b2b_ready_in_write got=%0d want=0", rdy_viol); end
        checks++; if ({bus8.cpu_run_out, bus8.word_count_out} !== {1'b1, 9'd8}) begin failures++; $display("FAIL b2b_final run=%b cnt=%0d want run=1 cnt=8", bus8.cpu_run_out, bus8.word_count_out); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial();
        test_overflow();
        test_done_with_last_byte();
        test_midload_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
